// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-aware 2:1 AXI-Stream arbiter with round-robin fairness and a registered output stage.
// Ownership is held from the first beat until the owner's tlast beat is accepted.
module axis_pkt_rr_arbiter #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    s1_tdata,
    input  logic             s1_tvalid,
    input  logic             s1_tlast,
    output logic             s1_tready,
    input  logic [DW-1:0]    s2_tdata,
    input  logic             s2_tvalid,
    input  logic             s2_tlast,
    output logic             s2_tready,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt_s1,
    output logic [CNT_W-1:0] pkt_cnt_s2
);

    typedef enum logic [1:0] {IDLE, OWN_S1, OWN_S2} state_t;

    state_t state, state_next;
    logic   last_owner_s2, last_owner_s2_next;
    logic   out_free;
    logic   s1_hs, s2_hs;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign out_free = !m_tvalid || m_tready;
    assign s1_hs    = s1_tvalid && s1_tready;
    assign s2_hs    = s2_tvalid && s2_tready;

    // State register; last_owner starts as s2 so s1 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_owner_s2 <= 1'b1;
        end else begin
            state         <= state_next;
            last_owner_s2 <= last_owner_s2_next;
        end
    end

    always_comb begin
        state_next         = state;
        last_owner_s2_next = last_owner_s2;
        case (state)
            IDLE: begin
                if (s1_tvalid && (!s2_tvalid || last_owner_s2))
                    state_next = OWN_S1;
                else if (s2_tvalid)
                    state_next = OWN_S2;
            end
            OWN_S1: begin
                if (s1_hs && s1_tlast) begin
                    state_next         = IDLE;
                    last_owner_s2_next = 1'b0;
                end
            end
            OWN_S2: begin
                if (s2_hs && s2_tlast) begin
                    state_next         = IDLE;
                    last_owner_s2_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is suppressed during reset so an in-flight beat is not consumed.
    always_comb begin
        s1_tready = !rst && (state == OWN_S1) && out_free;
        s2_tready = !rst && (state == OWN_S2) && out_free;
        grant     = {state == OWN_S2, state == OWN_S1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (s1_hs) begin
            m_tdata  <= s1_tdata;
            m_tlast  <= s1_tlast;
            m_tvalid <= 1'b1;
        end else if (s2_hs) begin
            m_tdata  <= s2_tdata;
            m_tlast  <= s2_tlast;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

    // Packets are counted at the source-side tlast handshake, not at the master side.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_s1 <= '0;
            pkt_cnt_s2 <= '0;
        end else begin
            if (s1_hs && s1_tlast)
                pkt_cnt_s1 <= pkt_cnt_s1 + CNT_ONE;
            if (s2_hs && s2_tlast)
                pkt_cnt_s2 <= pkt_cnt_s2 + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: packet-level sources, cycle model, per-cycle compare.
module tb_axis_pkt_rr_arbiter;

    localparam int DW    = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    s1_tdata, s2_tdata, m_tdata;
    logic             s1_tvalid, s1_tlast, s1_tready;
    logic             s2_tvalid, s2_tlast, s2_tready;
    logic             m_tvalid, m_tlast, m_tready;
    logic [1:0]       grant;
    logic [CNT_W-1:0] pkt_cnt_s1, pkt_cnt_s2;

    always #5 clk = ~clk;

    axis_pkt_rr_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(s2_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .pkt_cnt_s1(pkt_cnt_s1), .pkt_cnt_s2(pkt_cnt_s2)
    );

    logic ctl_rst = 1'b1, ctl_mready = 1'b1, en1 = 1'b1, en2 = 1'b1;
    int   q1[$], q2[$], out_log[$], owner_log[$];
    int   total = 0, bad = 0;
    logic [1:0] prev_grant = 2'b00;

    logic [1:0]       s_grant;
    logic [DW-1:0]    s_data;
    logic             s_valid, s_last, s_r1, s_r2;
    logic [CNT_W-1:0] s_c1, s_c2;

    // Reference model: owner as 0/1/2, output slot and counters as plain integers.
    int mod_owner, mod_last_owner, mod_data, mod_c1, mod_c2;
    bit mod_valid, mod_tlast, mod_on = 1'b0;

    always @(posedge clk) begin : model
        bit free, h1, h2;
        if (rst) begin
            mod_owner = 0; mod_last_owner = 2; mod_data = 0; mod_valid = 0; mod_tlast = 0;
            mod_c1 = 0; mod_c2 = 0; mod_on = 1'b1;
        end else if (mod_on) begin
            free = !mod_valid || m_tready;
            h1 = (mod_owner == 1) && free && s1_tvalid;
            h2 = (mod_owner == 2) && free && s2_tvalid;
            if (h1) begin
                mod_data = int'(s1_tdata); mod_tlast = s1_tlast; mod_valid = 1;
            end else if (h2) begin
                mod_data = int'(s2_tdata); mod_tlast = s2_tlast; mod_valid = 1;
            end else if (m_tready) begin
                mod_valid = 0; mod_tlast = 0;
            end
            if (mod_owner == 0) begin
                if (s1_tvalid && s2_tvalid) mod_owner = (mod_last_owner == 1) ? 2 : 1;
                else if (s1_tvalid)         mod_owner = 1;
                else if (s2_tvalid)         mod_owner = 2;
            end else if (h1 && s1_tlast) begin
                mod_c1 = (mod_c1 + 1) % (1 << CNT_W); mod_last_owner = 1; mod_owner = 0;
            end else if (h2 && s2_tlast) begin
                mod_c2 = (mod_c2 + 1) % (1 << CNT_W); mod_last_owner = 2; mod_owner = 0;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit free;
        logic [1:0] exp_grant;
        if (!mod_on) return;
        free = !mod_valid || m_tready;
        exp_grant = (mod_owner == 1) ? 2'b01 : (mod_owner == 2) ? 2'b10 : 2'b00;
        cmp("grant", grant, exp_grant);
        cmp("m_tvalid", m_tvalid, mod_valid);
        cmp("m_tlast", m_tlast, mod_tlast);
        cmp("m_tdata", m_tdata, mod_data);
        cmp("s1_tready", s1_tready, !rst && mod_owner == 1 && free);
        cmp("s2_tready", s2_tready, !rst && mod_owner == 2 && free);
        cmp("pkt_cnt_s1", pkt_cnt_s1, mod_c1);
        cmp("pkt_cnt_s2", pkt_cnt_s2, mod_c2);
    endtask

    // One clock: drive from the packet queues, check at negedge, retire handshakes after the edge.
    task automatic applyStimulus();
        int  b1, b2, acc_beat;
        bit  h1, h2, acc;
        b1 = (q1.size() > 0) ? q1[0] : 0;
        b2 = (q2.size() > 0) ? q2[0] : 0;
        rst = ctl_rst; m_tready = ctl_mready;
        s1_tvalid = en1 && (q1.size() > 0); s1_tdata = b1[DW-1:0]; s1_tlast = b1[8];
        s2_tvalid = en2 && (q2.size() > 0); s2_tdata = b2[DW-1:0]; s2_tlast = b2[8];
        @(negedge clk);
        checkOutput();
        s_grant = grant; s_data = m_tdata; s_valid = m_tvalid; s_last = m_tlast;
        s_r1 = s1_tready; s_r2 = s2_tready; s_c1 = pkt_cnt_s1; s_c2 = pkt_cnt_s2;
        if (grant !== prev_grant) begin
            if (grant === 2'b01) owner_log.push_back(1);
            else if (grant === 2'b10) owner_log.push_back(2);
            prev_grant = grant;
        end
        h1 = (s1_tvalid && s1_tready) === 1'b1;
        h2 = (s2_tvalid && s2_tready) === 1'b1;
        acc = (m_tvalid && m_tready) === 1'b1;
        acc_beat = int'(m_tdata) | (int'(m_tlast) << 8);
        @(posedge clk);
        #1;
        if (h1) void'(q1.pop_front());
        if (h2) void'(q2.pop_front());
        if (acc) out_log.push_back(acc_beat);
    endtask

    function automatic int beat(input int d, input bit l);
        return d | (int'(l) << 8);
    endfunction

    task automatic run_until_empty(input string name, input int max_cycles, input int drain, output int n);
        n = 0;
        while ((q1.size() > 0 || q2.size() > 0) && n < max_cycles) begin
            applyStimulus();
            n++;
        end
        cmp({name, "_timeout"}, n < max_cycles, 1);
        repeat (drain) applyStimulus();
    endtask

    task automatic check_log(input string name, input int act[$], input int exp[$]);
        cmp({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            cmp($sformatf("%s_%0d", name, i), act[i], exp[i]);
    endtask

    task automatic do_reset();
        ctl_rst = 1'b1;
        q1.delete(); q2.delete();
        repeat (2) applyStimulus();
        ctl_rst = 1'b0;
        cmp("rst_grant", s_grant, 2'b00);
        cmp("rst_m_tvalid", s_valid, 1'b0);
        cmp("rst_cnt_s1", s_c1, 0);
        cmp("rst_cnt_s2", s_c2, 0);
        out_log.delete(); owner_log.delete();
    endtask

    initial begin
        int n;
        int exp_q[$];
        rst = 1'b1; m_tready = 1'b1;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
        s2_tvalid = 1'b0; s2_tdata = '0; s2_tlast = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single s1 packet");
        do_reset();
        q1 = '{beat(8'h11, 0), beat(8'h22, 0), beat(8'h33, 1)};
        applyStimulus();
        cmp("t1_grant_c0", s_grant, 2'b00);
        applyStimulus();
        cmp("t1_grant_c1", s_grant, 2'b01);
        run_until_empty("t1", 20, 3, n);
        exp_q = '{32'h11, 32'h22, 32'h133};
        check_log("t1_out", out_log, exp_q);
        cmp("t1_cnt_s1", s_c1, 1);
        cmp("t1_grant_end", s_grant, 2'b00);

        $display("[TB] round robin");
        do_reset();
        q1 = '{beat(8'hA0, 0), beat(8'hA1, 1), beat(8'hA2, 0), beat(8'hA3, 1)};
        q2 = '{beat(8'hB0, 0), beat(8'hB1, 1), beat(8'hB2, 0), beat(8'hB3, 1)};
        run_until_empty("t2", 60, 2, n);
        cmp("t2_cycles", n, 12);
        exp_q = '{1, 2, 1, 2};
        check_log("t2_owner", owner_log, exp_q);
        exp_q = '{32'hA0, 32'h1A1, 32'hB0, 32'h1B1, 32'hA2, 32'h1A3, 32'hB2, 32'h1B3};
        check_log("t2_out", out_log, exp_q);
        cmp("t2_cnt_s1", s_c1, 2);
        cmp("t2_cnt_s2", s_c2, 2);

        $display("[TB] back-pressure on s2 packet");
        out_log.delete(); owner_log.delete();
        q2 = '{beat(8'hC0, 0), beat(8'hC1, 0), beat(8'hC2, 0), beat(8'hC3, 1)};
        for (int i = 0; i < 12; i++) begin
            ctl_mready = !(i >= 3 && i <= 5);
            applyStimulus();
            if (i >= 3 && i <= 5) begin
                cmp("t3_hold_data", s_data, 8'hC1);
                cmp("t3_hold_valid", s_valid, 1'b1);
                cmp("t3_s2_ready", s_r2, 1'b0);
                cmp("t3_s1_ready", s_r1, 1'b0);
            end
        end
        ctl_mready = 1'b1;
        exp_q = '{32'hC0, 32'hC1, 32'hC2, 32'h1C3};
        check_log("t3_out", out_log, exp_q);
        cmp("t3_cnt_s2", s_c2, 3);

        $display("[TB] owner stalls mid-packet");
        out_log.delete(); owner_log.delete();
        q1 = '{beat(8'hD0, 0), beat(8'hD1, 0), beat(8'hD2, 1)};
        q2 = '{beat(8'hE0, 1)};
        for (int i = 0; i < 14; i++) begin
            en1 = !(i >= 2 && i <= 6);
            applyStimulus();
            if (i >= 2 && i <= 6) begin
                cmp("t4_grant_held", s_grant, 2'b01);
                cmp("t4_s2_ready", s_r2, 1'b0);
            end
        end
        en1 = 1'b1;
        exp_q = '{1, 2};
        check_log("t4_owner", owner_log, exp_q);
        exp_q = '{32'hD0, 32'hD1, 32'h1D2, 32'h1E0};
        check_log("t4_out", out_log, exp_q);
        cmp("t4_cnt_s1", s_c1, 3);
        cmp("t4_cnt_s2", s_c2, 4);

        $display("[TB] counter wrap");
        do_reset();
        for (int i = 0; i < 15; i++) q2.push_back(beat(i, 1));
        run_until_empty("t5a", 100, 2, n);
        cmp("t5_cnt_15", s_c2, 15);
        q2.push_back(beat(8'h7F, 1));
        run_until_empty("t5b", 10, 2, n);
        cmp("t5_cnt_wrap", s_c2, 0);
        cmp("t5_beats", out_log.size(), 16);
        cmp("t5_cnt_s1", s_c1, 0);

        $display("[TB] reset mid-packet");
        q1 = '{beat(8'hF0, 0), beat(8'hF1, 0), beat(8'hF2, 1)};
        applyStimulus();
        applyStimulus();
        ctl_rst = 1'b1;
        applyStimulus();
        cmp("t6_s1_ready_in_rst", s_r1, 1'b0);
        ctl_rst = 1'b0;
        q1 = '{beat(8'h61, 1)};
        q2 = '{beat(8'h62, 1)};
        out_log.delete(); owner_log.delete();
        applyStimulus();
        cmp("t6_grant", s_grant, 2'b00);
        cmp("t6_m_tvalid", s_valid, 1'b0);
        cmp("t6_m_tdata", s_data, 0);
        cmp("t6_m_tlast", s_last, 1'b0);
        cmp("t6_cnt_s1", s_c1, 0);
        cmp("t6_cnt_s2", s_c2, 0);
        run_until_empty("t6", 20, 3, n);
        exp_q = '{1, 2};
        check_log("t6_owner", owner_log, exp_q);
        exp_q = '{32'h161, 32'h162};
        check_log("t6_out", out_log, exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
